// File: rtl/mem_arb_if.sv
// mem_arb_if -- request/response bundle for the two-port memory arbiter.
//   fetch port : f_req, f_addr -> f_gnt, f_done, f_rdata
//   data port  : d_req, d_rw, d_addr, d_wdata -> d_gnt, d_done, d_rdata
//   memory     : rw, addr_in, write_data -> ; read_data ->
//   status     : busy
// slave  = arbiter view, master = requesters/memory view.
interface mem_arb_if #(
  parameter int ADDR_LINE = 32,
  parameter int D_SIZE    = 32
);
  logic                 f_req;
  logic [ADDR_LINE-1:0] f_addr;
  logic                 f_gnt;
  logic                 f_done;
  logic [D_SIZE-1:0]    f_rdata;
  logic                 d_req;
  logic                 d_rw;
  logic [ADDR_LINE-1:0] d_addr;
  logic [D_SIZE-1:0]    d_wdata;
  logic                 d_gnt;
  logic                 d_done;
  logic [D_SIZE-1:0]    d_rdata;
  logic                 rw;
  logic [ADDR_LINE-1:0] addr_in;
  logic [D_SIZE-1:0]    write_data;
  logic [D_SIZE-1:0]    read_data;
  logic                 busy;

  modport slave (
    input  f_req, f_addr, d_req, d_rw, d_addr, d_wdata, read_data,
    output f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata,
           rw, addr_in, write_data, busy
  );
  modport master (
    output f_req, f_addr, d_req, d_rw, d_addr, d_wdata, read_data,
    input  f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata,
           rw, addr_in, write_data, busy
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb -- round-robin arbiter between a fetch (read-only) port and a
// data (read/write) port sharing one fixed-latency memory.
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset
//   bus     : mem_arb_if.slave (request ports, memory side, busy)
// Flow: IDLE samples requests -> ACCESS for MEM_LAT cycles -> RESP (done).
// All outputs are registered except busy, which decodes the state register.
module mem_arb #(
  parameter int ADDR_LINE = 32,
  parameter int D_SIZE    = 32,
  parameter int MEM_LAT   = 1
) (
  input  logic      clk_i,
  input  logic      reset_i,
  mem_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 last_d_q, last_d_d;   // 1: data port owned the last grant
  logic                 own_d_q, own_d_d;     // 1: data port owns current txn
  logic                 rw_q, rw_d;
  logic [ADDR_LINE-1:0] addr_q, addr_d;
  logic [D_SIZE-1:0]    wdata_q, wdata_d;
  logic                 f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
  logic                 f_done_q, f_done_d, d_done_q, d_done_d;
  logic [D_SIZE-1:0]    f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic                 pick_d;

  // Data port wins when it is the only requester, or on a tie when the
  // fetch port was granted last (last_d_q resets to 0, so D wins first tie).
  assign pick_d = bus.d_req & (~bus.f_req | ~last_d_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    own_d_d   = own_d_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    f_done_d  = 1'b0;
    d_done_d  = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        rw_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        if (bus.f_req || bus.d_req) begin
          state_d  = ACCESS;
          cnt_d    = 2'(MEM_LAT - 1);
          own_d_d  = pick_d;
          last_d_d = pick_d;
          rw_d     = pick_d ? bus.d_rw    : 1'b0;
          addr_d   = pick_d ? bus.d_addr  : bus.f_addr;
          wdata_d  = pick_d ? bus.d_wdata : '0;
          d_gnt_d  = pick_d;
          f_gnt_d  = ~pick_d;
        end
      end
      ACCESS: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
          // Memory data is valid on the edge closing the last ACCESS cycle.
          if (!rw_q) begin
            if (own_d_q) d_rdata_d = bus.read_data;
            else         f_rdata_d = bus.read_data;
          end
          d_done_d = own_d_q;
          f_done_d = ~own_d_q;
          rw_d     = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b0;
      own_d_q   <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      f_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      own_d_q   <= own_d_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f_gnt_q   <= f_gnt_d;
      d_gnt_q   <= d_gnt_d;
      f_done_q  <= f_done_d;
      d_done_q  <= d_done_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.f_gnt      = f_gnt_q;
  assign bus.d_gnt      = d_gnt_q;
  assign bus.f_done     = f_done_q;
  assign bus.d_done     = d_done_q;
  assign bus.f_rdata    = f_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.rw         = rw_q;
  assign bus.addr_in    = addr_q;
  assign bus.write_data = wdata_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb -- directed checks of mem_arb with MEM_LAT=1 (u_arb1) and
// MEM_LAT=3 (u_arb3). Inputs change and outputs are sampled on the falling
// edge; cycle 0 is the IDLE cycle whose closing rising edge samples a request.
module tb_mem_arb;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arb_if #(.ADDR_LINE(32), .D_SIZE(32)) if1 ();
  mem_arb_if #(.ADDR_LINE(32), .D_SIZE(32)) if3 ();

  mem_arb #(.ADDR_LINE(32), .D_SIZE(32), .MEM_LAT(1)) u_arb1 (
    .clk_i(clk), .reset_i(reset), .bus(if1));
  mem_arb #(.ADDR_LINE(32), .D_SIZE(32), .MEM_LAT(3)) u_arb3 (
    .clk_i(clk), .reset_i(reset), .bus(if3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_in();
    if1.f_req = 0; if1.f_addr = '0; if1.d_req = 0; if1.d_rw = 0;
    if1.d_addr = '0; if1.d_wdata = '0; if1.read_data = '0;
    if3.f_req = 0; if3.f_addr = '0; if3.d_req = 0; if3.d_rw = 0;
    if3.d_addr = '0; if3.d_wdata = '0; if3.read_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    tick(); tick();
  endtask

  initial begin
    logic [1:0] exp_g;
    clr_in();
    tick(); tick();
    // reset state
    chk("rst_busy",  {if1.busy, if3.busy}, 0);
    chk("rst_gnt",   {if1.f_gnt, if1.d_gnt, if3.f_gnt, if3.d_gnt}, 0);
    chk("rst_done",  {if1.f_done, if1.d_done, if3.f_done, if3.d_done}, 0);
    chk("rst_mem",   {if1.rw, if1.addr_in, if1.write_data}, 0);
    chk("rst_rdata", {if1.f_rdata, if1.d_rdata}, 0);

    // single fetch read, MEM_LAT=1
    reset = 0;
    if1.f_req = 1; if1.f_addr = 32'h40; if1.read_data = 32'hDEADBEEF;
    tick();  // cycle 1
    chk("f1_gnt",  {if1.f_gnt, if1.d_gnt}, 2'b10);
    chk("f1_addr", if1.addr_in, 32'h40);
    chk("f1_rw",   if1.rw, 0);
    chk("f1_busy", if1.busy, 1);
    if1.f_req = 0;
    tick();  // cycle 2
    chk("f1_done",  {if1.f_done, if1.d_done, if1.f_gnt}, 3'b100);
    chk("f1_rdata", if1.f_rdata, 32'hDEADBEEF);
    chk("f1_memz",  {if1.rw, if1.addr_in}, 0);
    tick();  // cycle 3
    chk("f1_idle", {if1.busy, if1.f_done}, 0);

    // first tie after reset goes to D, then F
    do_reset();
    reset = 0;
    if1.f_req = 1; if1.f_addr = 32'h40;
    if1.d_req = 1; if1.d_addr = 32'h20; if1.read_data = 32'h11111111;
    tick();
    chk("tie_dgnt", {if1.f_gnt, if1.d_gnt}, 2'b01);
    chk("tie_daddr", if1.addr_in, 32'h20);
    if1.d_req = 0;
    tick();
    chk("tie_ddone", {if1.f_done, if1.d_done}, 2'b01);
    chk("tie_drd",   if1.d_rdata, 32'h11111111);
    tick();  // IDLE, f_req sampled
    chk("tie_idle", if1.busy, 0);
    tick();
    chk("tie_fgnt", {if1.f_gnt, if1.d_gnt}, 2'b10);
    chk("tie_faddr", if1.addr_in, 32'h40);
    if1.f_req = 0; if1.read_data = 32'h22222222;
    tick();
    chk("tie_fdone", {if1.f_done, if1.d_done}, 2'b10);
    chk("tie_frd",   if1.f_rdata, 32'h22222222);
    chk("tie_dhold", if1.d_rdata, 32'h11111111);

    // continuous requests alternate D,F,D,F every MEM_LAT+2 = 5 cycles
    do_reset();
    reset = 0;
    if3.f_req = 1; if3.d_req = 1; if3.f_addr = 32'h100; if3.d_addr = 32'h200;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_g = (k == 1 || k == 11) ? 2'b01 : (k == 6 || k == 16) ? 2'b10 : 2'b00;
      chk($sformatf("rr_gnt_c%0d", k), {if3.f_gnt, if3.d_gnt}, exp_g);
      chk("rr_done_excl", if3.f_done & if3.d_done, 0);
    end

    // D read then D write, MEM_LAT=3
    do_reset();
    reset = 0;
    if3.d_req = 1; if3.d_addr = 32'h8; if3.read_data = 32'hAAAA5555;
    tick(); if3.d_req = 0;
    tick(); tick(); tick();  // cycle 4 = RESP
    chk("rd3_done",  if3.d_done, 1);
    chk("rd3_rdata", if3.d_rdata, 32'hAAAA5555);
    if3.d_req = 1; if3.d_rw = 1; if3.d_addr = 32'h10; if3.d_wdata = 32'h1234;
    if3.read_data = 32'h0BAD0BAD;
    tick();
    chk("wr_idle", if3.busy, 0);
    tick();
    chk("wr_gnt", if3.d_gnt, 1);
    if3.d_req = 0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      chk($sformatf("wr_bus_c%0d", k), {if3.rw, if3.addr_in, if3.write_data},
          {1'b1, 32'h10, 32'h1234});
      chk($sformatf("wr_nodone_c%0d", k), if3.d_done, 0);
    end
    tick();
    chk("wr_done",  if3.d_done, 1);
    chk("wr_rdata", if3.d_rdata, 32'hAAAA5555);
    chk("wr_memz",  {if3.rw, if3.addr_in, if3.write_data}, 0);
    if3.d_rw = 0;
    tick();

    // reset in 2nd ACCESS cycle drops the transaction
    if3.d_req = 1; if3.d_addr = 32'h30; if3.read_data = 32'h77777777;
    tick();
    chk("ra_gnt", if3.d_gnt, 1);
    if3.d_req = 0;
    tick();  // 2nd ACCESS cycle
    reset = 1;
    tick();
    chk("ra_zero", {if3.busy, if3.rw, if3.addr_in, if3.d_done, if3.d_gnt}, 0);
    chk("ra_rdata", if3.d_rdata, 0);
    reset = 0;
    tick();
    chk("ra_nodone", {if3.d_done, if3.f_done, if3.busy}, 0);
    if3.f_req = 1; if3.f_addr = 32'h44; if3.read_data = 32'h5A5A5A5A;
    tick();
    chk("ra_fgnt", {if3.f_gnt, if3.d_gnt}, 2'b10);
    if3.f_req = 0;
    tick(); tick(); tick();
    chk("ra_fdone",  if3.f_done, 1);
    chk("ra_frdata", if3.f_rdata, 32'h5A5A5A5A);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
